// File: rtl/memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_arbiter: shares one RAM port between instruction fetch and data     |
// | access; data wins, a streak limit stops fetch starvation, timeout guards.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        err
);

  localparam int          SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [1:0]  RS_ACCESS  = 2'd2;
  localparam logic [1:0]  RS_ERROR   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    tcnt_q, tcnt_d;

  logic dreq, ireq;
  assign dreq = dREN | dWEN;
  assign ireq = iREN;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    tcnt_d   = tcnt_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'd0;
    dload    = 32'd0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ireq) streak_d = '0;
        if (dreq && !(ireq && streak_q == STREAK_MAX)) begin
          state_d = DGNT;
          if (ireq && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (ireq) begin
          state_d  = IGNT;
          streak_d = '0;
        end
      end

      DGNT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == RS_ACCESS) begin
            dwait   = 1'b0;
            dload   = dWEN ? 32'd0 : ramload;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR || tcnt_q == TMO_LAST) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end

      IGNT: begin
        if (!ireq) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RS_ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR || tcnt_q == TMO_LAST) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) tcnt_d = 8'd0;

    // Reset forces the quiescent port values immediately, aborting any grant.
    if (RST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = 32'd0;
      dload    = 32'd0;
      err      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      tcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memory_arbiter: directed self-checking bench for memory_arbiter.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN, iwait, dwait, err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  memory_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
    iaddr = 32'h0; daddr = 32'h80; dstore = 32'h77; ramload = 32'h1111_2222;
    ramstate = ACCESS;
    tick(); tick();
    // requests during reset must not reach the RAM
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_dload", dload, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    RST = 1'b0; iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick();

    // 1: lone instruction fetch
    iREN = 1'b1; iaddr = 32'h40;
    #1;
    chk("t1_c0_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t1_c0_iwait", {31'd0, iwait}, 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    chk("t1_c1_ramREN", {31'd0, ramREN}, 32'd1);
    chk("t1_c1_ramaddr", ramaddr, 32'h40);
    chk("t1_c1_iwait", {31'd0, iwait}, 32'd0);
    chk("t1_c1_iload", iload, 32'hDEAD_BEEF);
    chk("t1_c1_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("t1_c2_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t1_c2_idle_iwait", {31'd0, iwait}, 32'd1);
    iREN = 1'b0; ramstate = FREE;
    tick();

    // 2: streak limit hands the 5th grant to the instruction side
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
      tick();
      chk("t2_dgnt_ramWEN", {31'd0, ramWEN}, 32'd1);
      chk("t2_dgnt_ramstore", ramstore, 32'h1234);
      chk("t2_dgnt_ramaddr", ramaddr, 32'h80);
      chk("t2_dgnt_dwait", {31'd0, dwait}, 32'd0);
      chk("t2_dgnt_iwait", {31'd0, iwait}, 32'd1);
      chk("t2_dgnt_iload", iload, 32'd0);
      tick();
    end
    tick();
    chk("t2_ignt_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("t2_ignt_ramREN", {31'd0, ramREN}, 32'd1);
    chk("t2_ignt_ramaddr", ramaddr, 32'h44);
    chk("t2_ignt_iwait", {31'd0, iwait}, 32'd0);
    chk("t2_ignt_iload", iload, 32'h0BAD_F00D);
    chk("t2_ignt_dwait", {31'd0, dwait}, 32'd1);
    tick();
    iREN = 1'b0; dWEN = 1'b0;
    tick();

    // 3: write wins over read; then a plain read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h90; dstore = 32'h5A5A; ramload = 32'hCAFE_F00D;
    tick();
    chk("t3_wr_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("t3_wr_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t3_wr_dwait", {31'd0, dwait}, 32'd0);
    chk("t3_wr_dload", dload, 32'd0);
    tick();
    dWEN = 1'b0;
    tick();
    chk("t3_rd_ramREN", {31'd0, ramREN}, 32'd1);
    chk("t3_rd_ramstore", ramstore, 32'h5A5A);
    chk("t3_rd_dload", dload, 32'hCAFE_F00D);
    tick();
    dREN = 1'b0;
    tick();

    // 4: timeout on a RAM stuck BUSY
    dREN = 1'b1; daddr = 32'hA0; ramstate = BUSY;
    tick();
    for (int k = 1; k <= 255; k++) begin
      chk("t4_busy_ramREN", {31'd0, ramREN}, 32'd1);
      chk("t4_busy_dwait", {31'd0, dwait}, 32'd1);
      chk("t4_busy_err", {31'd0, err}, (k == 255) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t4_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t4_idle_err", {31'd0, err}, 32'd0);
    tick();
    chk("t4_regrant_ramREN", {31'd0, ramREN}, 32'd1);
    chk("t4_regrant_err", {31'd0, err}, 32'd0);
    dREN = 1'b0;
    #1;
    chk("t4_drop_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t4_drop_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("t4_after_drop_ramREN", {31'd0, ramREN}, 32'd0);
    tick();

    // 5: RAM ERROR on first grant cycle
    dREN = 1'b1; daddr = 32'hC0; ramstate = ERROR;
    tick();
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("t5_idle_err", {31'd0, err}, 32'd0);
    chk("t5_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t5_idle_dwait", {31'd0, dwait}, 32'd1);
    dREN = 1'b0;
    tick();

    // 6: reset in the middle of a write grant
    dWEN = 1'b1; daddr = 32'hB0; dstore = 32'h55; ramstate = BUSY;
    tick();
    chk("t6_dgnt_ramWEN", {31'd0, ramWEN}, 32'd1);
    RST = 1'b1;
    tick();
    chk("t6_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("t6_rst_ramaddr", ramaddr, 32'd0);
    chk("t6_rst_dwait", {31'd0, dwait}, 32'd1);
    RST = 1'b0; ramstate = ACCESS;
    #1;
    chk("t6_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
    tick();
    chk("t6_regrant_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("t6_regrant_ramstore", ramstore, 32'h55);
    chk("t6_regrant_dwait", {31'd0, dwait}, 32'd0);
    dWEN = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
